// File: rtl/regfile_sequencer.sv
// Operand-fetch / write-back controller for the ternary register file.
// Serialises a decoded instruction into read, ALU issue, wait and write-back
// steps on the shared num1 port. Write-back is suppressed when a fetched
// operand holds an illegal trit (2'b11) or when the ALU never answers.
module regfile_sequencer #(
    parameter int WORD_SIZE     = 9,
    parameter int REG_ADDR_SIZE = 2,
    parameter int ALU_TIMEOUT   = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic [2*REG_ADDR_SIZE-1:0] rd_addr,
    input  logic [2*REG_ADDR_SIZE-1:0] rs1_addr,
    input  logic [2*REG_ADDR_SIZE-1:0] rs2_addr,
    input  logic                       wb_en,
    input  logic                       clear_req,
    output logic [2*REG_ADDR_SIZE-1:0] rf_num1,
    output logic [2*REG_ADDR_SIZE-1:0] rf_num2,
    output logic                       rf_get_enable,
    output logic                       rf_set_enable,
    output logic                       rf_reset_enable,
    output logic [2*WORD_SIZE-1:0]     rf_set_val,
    input  logic [2*WORD_SIZE-1:0]     rf_out1,
    input  logic [2*WORD_SIZE-1:0]     rf_out2,
    output logic                       alu_valid,
    output logic [2*WORD_SIZE-1:0]     alu_a,
    output logic [2*WORD_SIZE-1:0]     alu_b,
    input  logic                       alu_result_valid,
    input  logic [2*WORD_SIZE-1:0]     alu_result,
    output logic                       done,
    output logic                       err_illegal,
    output logic                       err_timeout
);

    localparam int DW = 2 * WORD_SIZE;
    localparam int AW = 2 * REG_ADDR_SIZE;
    localparam int CW = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LIMIT = CW'(ALU_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_READ,
        ST_CAPT,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [AW-1:0]   rd_q;
    logic [AW-1:0]   rs1_q;
    logic [AW-1:0]   rs2_q;
    logic            wb_en_q;
    logic [CW-1:0]   tmo_cnt;
    logic [CW-1:0]   tmo_next;
    logic            operand_illegal;

    // True when any trit of the word carries the unused 2'b11 encoding.
    function automatic logic has_illegal(input logic [DW-1:0] w);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < WORD_SIZE; i++) begin
            if (w[2*i +: 2] == 2'b11) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign tmo_next        = tmo_cnt + CW'(1);
    assign operand_illegal = has_illegal(rf_out1) | has_illegal(rf_out2);

    // State register; reset aborts any instruction in flight back to IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobe decode; strobes depend only on the current state
    // and latched registers, so no input reaches an output combinationally.
    always_comb begin
        next_state      = state;
        instr_ready     = 1'b0;
        rf_num1         = '0;
        rf_num2         = '0;
        rf_get_enable   = 1'b0;
        rf_set_enable   = 1'b0;
        rf_reset_enable = 1'b0;
        alu_valid       = 1'b0;
        done            = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (clear_req) begin
                    next_state = ST_CLEAR;
                end else if (instr_valid) begin
                    next_state = ST_READ;
                end
            end
            ST_CLEAR: begin
                rf_reset_enable = 1'b1;
                next_state      = ST_DONE;
            end
            ST_READ: begin
                rf_num1       = rs1_q;
                rf_num2       = rs2_q;
                rf_get_enable = 1'b1;
                next_state    = ST_CAPT;
            end
            ST_CAPT: begin
                next_state = operand_illegal ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                alu_valid  = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_result_valid) begin
                    next_state = wb_en_q ? ST_WRITE : ST_DONE;
                end else if (tmo_next == TMO_LIMIT) begin
                    next_state = ST_DONE;
                end
            end
            ST_WRITE: begin
                rf_num1       = rd_q;
                rf_set_enable = 1'b1;
                next_state    = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: latch the instruction on accept, capture operands, time the
    // ALU and hold its result; error flags stay set until the next accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            wb_en_q     <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            rf_set_val  <= '0;
            tmo_cnt     <= '0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!clear_req && instr_valid) begin
                        rd_q        <= rd_addr;
                        rs1_q       <= rs1_addr;
                        rs2_q       <= rs2_addr;
                        wb_en_q     <= wb_en;
                        err_illegal <= 1'b0;
                        err_timeout <= 1'b0;
                    end
                end
                ST_CAPT: begin
                    alu_a <= rf_out1;
                    alu_b <= rf_out2;
                    if (operand_illegal) begin
                        err_illegal <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt <= '0;
                end
                ST_WAIT: begin
                    if (alu_result_valid) begin
                        rf_set_val <= alu_result;
                    end else begin
                        tmo_cnt <= tmo_next;
                        if (tmo_next == TMO_LIMIT) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: a behavioural register file and
// ternary-adder ALU surround the DUT, and an instruction-level model predicts
// register contents, error flags, strobe counts and retire latency.
module tb_regfile_sequencer;

    localparam int DW = 18;
    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [AW-1:0] rd_addr = '0;
    logic [AW-1:0] rs1_addr = '0;
    logic [AW-1:0] rs2_addr = '0;
    logic          wb_en = 1'b0;
    logic          clear_req = 1'b0;
    logic [AW-1:0] rf_num1;
    logic [AW-1:0] rf_num2;
    logic          rf_get_enable;
    logic          rf_set_enable;
    logic          rf_reset_enable;
    logic [DW-1:0] rf_set_val;
    logic [DW-1:0] rf_out1 = '0;
    logic [DW-1:0] rf_out2 = '0;
    logic          alu_valid;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic          alu_result_valid = 1'b0;
    logic [DW-1:0] alu_result = '0;
    logic          done;
    logic          err_illegal;
    logic          err_timeout;

    logic [DW-1:0] rf_mem   [16];
    logic [DW-1:0] exp_regs [16];
    logic          load_req = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    int            alu_delay = 1;
    int            alu_cnt = 0;

    int   total = 0;
    int   bad = 0;
    int   n_set, n_get, n_alu, n_rst, n_ovl, n_done;
    logic exp_ill = 1'b0;
    logic exp_tmo = 1'b0;

    regfile_sequencer #(
        .WORD_SIZE(9),
        .REG_ADDR_SIZE(2),
        .ALU_TIMEOUT(16)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .rd_addr(rd_addr),
        .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr),
        .wb_en(wb_en),
        .clear_req(clear_req),
        .rf_num1(rf_num1),
        .rf_num2(rf_num2),
        .rf_get_enable(rf_get_enable),
        .rf_set_enable(rf_set_enable),
        .rf_reset_enable(rf_reset_enable),
        .rf_set_val(rf_set_val),
        .rf_out1(rf_out1),
        .rf_out2(rf_out2),
        .alu_valid(alu_valid),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_result_valid(alu_result_valid),
        .alu_result(alu_result),
        .done(done),
        .err_illegal(err_illegal),
        .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    // Balanced-ternary word to integer.
    function automatic int tdec(input logic [DW-1:0] w);
        int v = 0;
        int p = 1;
        for (int i = 0; i < 9; i++) begin
            if (w[2*i +: 2] == 2'b01) v += p;
            if (w[2*i +: 2] == 2'b10) v -= p;
            p *= 3;
        end
        return v;
    endfunction

    // Integer to balanced-ternary word, dropping trits beyond the ninth.
    function automatic logic [DW-1:0] tenc(input int val);
        logic [DW-1:0] w = '0;
        int v = val;
        int r;
        for (int i = 0; i < 9; i++) begin
            r = ((v % 3) + 3) % 3;
            if (r == 1) begin
                w[2*i +: 2] = 2'b01;
                v = (v - 1) / 3;
            end else if (r == 2) begin
                w[2*i +: 2] = 2'b10;
                v = (v + 1) / 3;
            end else begin
                v = v / 3;
            end
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] tadd(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return tenc(tdec(a) + tdec(b));
    endfunction

    function automatic logic isIllegal(input logic [DW-1:0] w);
        logic r = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (w[2*i +: 2] == 2'b11) r = 1'b1;
        end
        return r;
    endfunction

    // Register file: registered reads, write and clear on the clock edge.
    always @(posedge clock) begin
        if (load_req) begin
            rf_mem[load_addr] <= load_data;
        end else if (rf_reset_enable) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
        end else if (rf_set_enable) begin
            rf_mem[rf_num1] <= rf_set_val;
        end
        if (rf_get_enable) begin
            rf_out1 <= rf_mem[rf_num1];
            rf_out2 <= rf_mem[rf_num2];
        end
    end

    // ALU: adds its operands and answers alu_delay cycles after the issue
    // pulse; a delay of 0 means it never answers.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_result_valid <= 1'b0;
            alu_cnt          <= 0;
        end else begin
            alu_result_valid <= 1'b0;
            if (alu_valid) begin
                if (alu_delay == 1) begin
                    alu_result_valid <= 1'b1;
                    alu_result       <= tadd(alu_a, alu_b);
                    alu_cnt          <= 0;
                end else if (alu_delay == 0) begin
                    alu_cnt <= 0;
                end else begin
                    alu_cnt <= alu_delay - 1;
                end
            end else if (alu_cnt > 0) begin
                alu_cnt <= alu_cnt - 1;
                if (alu_cnt == 1) begin
                    alu_result_valid <= 1'b1;
                    alu_result       <= tadd(alu_a, alu_b);
                end
            end
        end
    end

    // Counts the comparison and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Advances one clock and tallies the strobes seen in the new cycle.
    task automatic tickClock();
        @(posedge clock);
        #1;
        if (rf_set_enable) n_set++;
        if (rf_get_enable) n_get++;
        if (alu_valid) n_alu++;
        if (rf_reset_enable) n_rst++;
        if (rf_set_enable && rf_get_enable) n_ovl++;
        if (done) n_done++;
    endtask

    task automatic clearTallies();
        n_set = 0; n_get = 0; n_alu = 0; n_rst = 0; n_ovl = 0; n_done = 0;
    endtask

    task automatic loadReg(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        load_req  = 1'b1;
        load_addr = addr;
        load_data = data;
        tickClock();
        load_req  = 1'b0;
        exp_regs[addr] = data;
    endtask

    task automatic reloadRegs();
        logic [DW-1:0] w;
        for (int r = 0; r < 16; r++) begin
            w = '0;
            for (int t = 0; t < 9; t++) begin
                w[2*t +: 2] = 2'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 7) == 0) begin
                w[2*$urandom_range(0, 8) +: 2] = 2'b11;
            end
            loadReg(4'(r), w);
        end
    endtask

    task automatic compareRegs(input string tag);
        int nbad = 0;
        for (int r = 0; r < 16; r++) begin
            if (rf_mem[r] !== exp_regs[r]) nbad++;
        end
        checkOutput(tag, 32'(nbad), 32'd0);
    endtask

    // Issues one instruction (or a clear) and checks its whole lifetime.
    task automatic applyStimulus(input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                                 input logic [AW-1:0] rs2, input logic wb,
                                 input int delay, input logic clr);
        int edges;
        int lat;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic ill;
        logic tmo;
        a = exp_regs[rs1];
        b = exp_regs[rs2];
        ill = 1'b0;
        tmo = 1'b0;
        checkOutput("ready_idle", 32'(instr_ready), 32'd1);
        alu_delay   = delay;
        rd_addr     = rd;
        rs1_addr    = rs1;
        rs2_addr    = rs2;
        wb_en       = wb;
        clear_req   = clr;
        instr_valid = 1'b1;
        clearTallies();
        tickClock();
        edges = 1;
        instr_valid = 1'b0;
        clear_req   = 1'b0;
        if (!clr) begin
            checkOutput("ready_busy", 32'(instr_ready), 32'd0);
            checkOutput("flags_on_accept", 32'({err_illegal, err_timeout}), 32'd0);
        end
        while (!done && edges < 60) begin
            tickClock();
            edges++;
        end
        if (clr) begin
            lat = 2;
            for (int r = 0; r < 16; r++) exp_regs[r] = '0;
        end else begin
            ill = isIllegal(a) | isIllegal(b);
            tmo = !ill && (delay == 0 || delay > 16);
            exp_ill = ill;
            exp_tmo = tmo;
            if (ill) lat = 3;
            else if (tmo) lat = 20;
            else lat = wb ? 5 + delay : 4 + delay;
            if (!ill && !tmo && wb) exp_regs[rd] = tadd(a, b);
        end
        checkOutput("latency", 32'(edges), 32'(lat));
        checkOutput("err_illegal", 32'(err_illegal), 32'(exp_ill));
        checkOutput("err_timeout", 32'(err_timeout), 32'(exp_tmo));
        checkOutput("set_pulses", 32'(n_set), 32'((!clr && !ill && !tmo && wb) ? 1 : 0));
        checkOutput("get_pulses", 32'(n_get), 32'(clr ? 0 : 1));
        checkOutput("alu_pulses", 32'(n_alu), 32'((clr || ill) ? 0 : 1));
        checkOutput("clear_pulses", 32'(n_rst), 32'(clr ? 1 : 0));
        checkOutput("set_get_overlap", 32'(n_ovl), 32'd0);
        if (!clr) begin
            checkOutput("alu_a", 32'(alu_a), 32'(a));
            checkOutput("alu_b", 32'(alu_b), 32'(b));
        end
        tickClock();
        checkOutput("done_single", 32'(done), 32'd0);
        checkOutput("done_count", 32'(n_done), 32'd1);
        compareRegs("rf_contents");
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] rr;
        logic [3:0] r1;
        logic [3:0] r2;
        int sel;
        int dly;

        // Reset state, sampled while reset is still asserted.
        #12;
        checkOutput("rst_strobes",
                    32'({rf_get_enable, rf_set_enable, rf_reset_enable, alu_valid, done}), 32'd0);
        checkOutput("rst_flags", 32'({err_illegal, err_timeout}), 32'd0);
        checkOutput("rst_data", 32'(alu_a | alu_b | rf_set_val), 32'd0);
        checkOutput("rst_nums", 32'({rf_num1, rf_num2}), 32'd0);
        #6 reset_n = 1'b1;
        clearTallies();
        tickClock();
        checkOutput("ready_after_rst", 32'(instr_ready), 32'd1);

        // Directed register image: +1, -1, and one word with an illegal trit.
        reloadRegs();
        loadReg(4'd1, 18'h00001);
        loadReg(4'd2, 18'h00002);
        loadReg(4'd7, 18'h0000C);

        // +1 + -1 into r3, one-cycle ALU: retires six cycles after accept.
        applyStimulus(4'd3, 4'd1, 4'd2, 1'b1, 1, 1'b0);
        checkOutput("r3_zero", 32'(rf_mem[3]), 32'd0);
        // Result discarded when write-back is off.
        applyStimulus(4'd4, 4'd1, 4'd1, 1'b0, 2, 1'b0);
        // Illegal operand: no ALU issue, no write.
        applyStimulus(4'd5, 4'd7, 4'd1, 1'b1, 1, 1'b0);
        // Silent ALU times out; next accept clears the flag.
        applyStimulus(4'd6, 4'd1, 4'd2, 1'b1, 0, 1'b0);
        // Result in the last permitted WAIT cycle still wins.
        applyStimulus(4'd6, 4'd1, 4'd3, 1'b1, 16, 1'b0);
        // One cycle later is a timeout; the late answer lands outside WAIT.
        applyStimulus(4'd8, 4'd2, 4'd2, 1'b1, 17, 1'b0);

        // Reset while waiting on the ALU: nothing is written afterwards.
        alu_delay   = 5;
        rd_addr     = 4'd10;
        rs1_addr    = 4'd1;
        rs2_addr    = 4'd2;
        wb_en       = 1'b1;
        instr_valid = 1'b1;
        clearTallies();
        tickClock();
        instr_valid = 1'b0;
        for (int i = 0; i < 4; i++) tickClock();
        checkOutput("pre_rst_alu_a", 32'(alu_a), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midrst_strobes",
                    32'({rf_get_enable, rf_set_enable, rf_reset_enable, alu_valid, done}), 32'd0);
        checkOutput("midrst_data", 32'(alu_a | alu_b | rf_set_val), 32'd0);
        checkOutput("midrst_flags", 32'({err_illegal, err_timeout}), 32'd0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        exp_ill = 1'b0;
        exp_tmo = 1'b0;
        clearTallies();
        for (int i = 0; i < 12; i++) tickClock();
        checkOutput("postrst_no_write", 32'(n_set), 32'd0);
        checkOutput("postrst_no_done", 32'(n_done), 32'd0);
        checkOutput("postrst_ready", 32'(instr_ready), 32'd1);
        compareRegs("postrst_rf");

        // Clear beats a simultaneous instruction, which is then taken next.
        applyStimulus(4'd9, 4'd1, 4'd2, 1'b1, 1, 1'b1);
        applyStimulus(4'd9, 4'd1, 4'd2, 1'b1, 1, 1'b0);

        // Randomised traffic against the model.
        reloadRegs();
        for (int n = 0; n < 40; n++) begin
            if (n % 10 == 9) reloadRegs();
            rr = 4'($urandom_range(0, 15));
            r1 = 4'($urandom_range(0, 15));
            r2 = 4'($urandom_range(0, 15));
            sel = $urandom_range(0, 9);
            if (sel <= 5) dly = $urandom_range(1, 3);
            else if (sel == 6) dly = 16;
            else if (sel == 7) dly = 17;
            else if (sel == 8) dly = 0;
            else dly = $urandom_range(4, 8);
            applyStimulus(rr, r1, r2, 1'($urandom_range(0, 1)), dly,
                          ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
